// File: rtl/id_stage_hz.sv
// id_stage_hz: decode stage for the 5-stage MIPS datapath.
// Contents:
//   - register file with a write-through bypass of the WB port
//   - immediate extension
//   - load-use hazard detection with bubble insertion
//   - ID/EX pipeline register with a valid bit
//   - saturating stall counter
// Optional feature: define ID_BRANCH_CMP_EN to register the rs==rt comparator
// into Eq. Without it no comparator is built and Eq is tied to 0.
module id_stage_hz #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5,
    parameter int ZREG = 1,
    parameter int SCW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           En,
    input  logic           Clr,
    input  logic           Valid_i,
    input  logic [AW-1:0]  RefAddr_i,
    input  logic [25:0]    Instr,
    input  logic           ZeroExt,
    input  logic           WriteReg,
    input  logic [RAW-1:0] wAddr,
    input  logic [DW-1:0]  wData,
    input  logic           ExMemRead,
    input  logic [RAW-1:0] ExRtAddr,
    output logic           Stall,
    output logic           Valid,
    output logic [AW-1:0]  RefAddr,
    output logic [DW-1:0]  rData1,
    output logic [DW-1:0]  rData2,
    output logic [DW-1:0]  Offset,
    output logic [RAW-1:0] RsAddr,
    output logic [RAW-1:0] RtAddr,
    output logic [RAW-1:0] RdAddr,
    output logic           Eq,
    output logic [SCW-1:0] StallCnt
);

    localparam logic [RAW-1:0] ZERO_ADDR = {RAW{1'b0}};
    localparam logic [SCW-1:0] CNT_MAX   = {SCW{1'b1}};
    localparam logic [SCW-1:0] CNT_ONE   = {{(SCW-1){1'b0}}, 1'b1};

    // Immediate extension: zero-extend for logical immediates, sign-extend otherwise.
    function automatic logic [DW-1:0] extendImm(input logic [15:0] imm, input logic zext);
        if (zext) begin
            return {{(DW-16){1'b0}}, imm};
        end else begin
            return {{(DW-16){imm[15]}}, imm};
        end
    endfunction

    logic [DW-1:0]  regFile_r [NREG];
    logic [RAW-1:0] rsAddr_s;
    logic [RAW-1:0] rtAddr_s;
    logic [RAW-1:0] rdAddr_s;
    logic           wrOk_s;
    logic [DW-1:0]  rsData_s;
    logic [DW-1:0]  rtData_s;
    logic [DW-1:0]  extImm_s;
    logic           stall_s;

    assign rsAddr_s = RAW'(Instr[25:21]);
    assign rtAddr_s = RAW'(Instr[20:16]);
    assign rdAddr_s = RAW'(Instr[15:11]);
    assign extImm_s = extendImm(Instr[15:0], ZeroExt);
    assign Stall    = stall_s;

    // WB write qualifier: in-range address, and not the hardwired zero register.
    always_comb begin
        wrOk_s = 1'b0;
        if (WriteReg && (int'(wAddr) < NREG) && !((ZREG != 0) && (wAddr == ZERO_ADDR))) begin
            wrOk_s = 1'b1;
        end else begin
            wrOk_s = 1'b0;
        end
    end

    // rs read port with write-through bypass so a WB->ID dependency needs no bubble.
    always_comb begin
        rsData_s = {DW{1'b0}};
        if (wrOk_s && (wAddr == rsAddr_s)) begin
            rsData_s = wData;
        end else if (int'(rsAddr_s) < NREG) begin
            rsData_s = regFile_r[rsAddr_s];
        end else begin
            rsData_s = {DW{1'b0}};
        end
    end

    // rt read port, same bypass rule as rs.
    always_comb begin
        rtData_s = {DW{1'b0}};
        if (wrOk_s && (wAddr == rtAddr_s)) begin
            rtData_s = wData;
        end else if (int'(rtAddr_s) < NREG) begin
            rtData_s = regFile_r[rtAddr_s];
        end else begin
            rtData_s = {DW{1'b0}};
        end
    end

    // Load-use hazard: rt is matched even for I-type instructions (conservative).
    always_comb begin
        stall_s = 1'b0;
        if (Valid_i && ExMemRead
            && ((ExRtAddr != ZERO_ADDR) || (ZREG == 0))
            && ((ExRtAddr == rsAddr_s) || (ExRtAddr == rtAddr_s))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Register file storage; the write lands on the edge, the bypass covers the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regFile_r[i] <= {DW{1'b0}};
            end
        end else if (wrOk_s) begin
            regFile_r[wAddr] <= wData;
        end
    end

    // ID/EX register: flush beats hold, hold beats bubble, bubble beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid    <= 1'b0;
            RefAddr  <= {AW{1'b0}};
            rData1   <= {DW{1'b0}};
            rData2   <= {DW{1'b0}};
            Offset   <= {DW{1'b0}};
            RsAddr   <= ZERO_ADDR;
            RtAddr   <= ZERO_ADDR;
            RdAddr   <= ZERO_ADDR;
            StallCnt <= {SCW{1'b0}};
        end else if (Clr) begin
            Valid    <= 1'b0;
            RefAddr  <= {AW{1'b0}};
            rData1   <= {DW{1'b0}};
            rData2   <= {DW{1'b0}};
            Offset   <= {DW{1'b0}};
            RsAddr   <= ZERO_ADDR;
            RtAddr   <= ZERO_ADDR;
            RdAddr   <= ZERO_ADDR;
        end else if (!En) begin
            Valid    <= Valid;
        end else if (stall_s) begin
            Valid    <= 1'b0;
            RefAddr  <= {AW{1'b0}};
            rData1   <= {DW{1'b0}};
            rData2   <= {DW{1'b0}};
            Offset   <= {DW{1'b0}};
            RsAddr   <= ZERO_ADDR;
            RtAddr   <= ZERO_ADDR;
            RdAddr   <= ZERO_ADDR;
            if (StallCnt != CNT_MAX) begin
                StallCnt <= StallCnt + CNT_ONE;
            end
        end else begin
            Valid    <= Valid_i;
            RefAddr  <= RefAddr_i;
            rData1   <= rsData_s;
            rData2   <= rtData_s;
            Offset   <= extImm_s;
            RsAddr   <= rsAddr_s;
            RtAddr   <= rtAddr_s;
            RdAddr   <= rdAddr_s;
        end
    end

`ifdef ID_BRANCH_CMP_EN
    logic eq_r;
    assign Eq = eq_r;

    // Early branch compare on the bypassed operands, same priority as the data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_r <= 1'b0;
        end else if (Clr) begin
            eq_r <= 1'b0;
        end else if (!En) begin
            eq_r <= eq_r;
        end else if (stall_s) begin
            eq_r <= 1'b0;
        end else begin
            eq_r <= (rsData_s == rtData_s);
        end
    end
`else
    assign Eq = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_hz.sv
// Testbench for id_stage_hz: a vector table applied cycle by cycle with a
// scoreboard queue for the registered outputs, then a stall-counter saturation
// run and a mid-run asynchronous reset.
module tb_id_stage_hz;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int RAW = 5;
    localparam int SCW = 4;
`ifdef ID_BRANCH_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           En;
    logic           Clr;
    logic           Valid_i;
    logic [AW-1:0]  RefAddr_i;
    logic [25:0]    Instr;
    logic           ZeroExt;
    logic           WriteReg;
    logic [RAW-1:0] wAddr;
    logic [DW-1:0]  wData;
    logic           ExMemRead;
    logic [RAW-1:0] ExRtAddr;
    logic           Stall;
    logic           Valid;
    logic [AW-1:0]  RefAddr;
    logic [DW-1:0]  rData1;
    logic [DW-1:0]  rData2;
    logic [DW-1:0]  Offset;
    logic [RAW-1:0] RsAddr;
    logic [RAW-1:0] RtAddr;
    logic [RAW-1:0] RdAddr;
    logic           Eq;
    logic [SCW-1:0] StallCnt;

    id_stage_hz #(.DW(DW), .AW(AW), .NREG(32), .RAW(RAW), .ZREG(1), .SCW(SCW)) dut (
        .clk(clk), .rst(rst), .En(En), .Clr(Clr), .Valid_i(Valid_i),
        .RefAddr_i(RefAddr_i), .Instr(Instr), .ZeroExt(ZeroExt),
        .WriteReg(WriteReg), .wAddr(wAddr), .wData(wData),
        .ExMemRead(ExMemRead), .ExRtAddr(ExRtAddr), .Stall(Stall),
        .Valid(Valid), .RefAddr(RefAddr), .rData1(rData1), .rData2(rData2),
        .Offset(Offset), .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr),
        .Eq(Eq), .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, clr, vld;
        logic [31:0] refA;
        logic [25:0] instr;
        logic        zext, wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exMem;
        logic [4:0]  exRt;
        logic        xStall, xValid;
        logic [31:0] xRef, xRd1, xRd2, xOff;
        logic [4:0]  xRs, xRt, xRd;
        logic        xEq;
        logic [3:0]  xCnt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] refA, rd1, rd2, off;
        logic [4:0]  rs, rt, rd;
        logic        eq;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [25:0] mkI(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        exp_t g;
        En = v.en; Clr = v.clr; Valid_i = v.vld; RefAddr_i = v.refA;
        Instr = v.instr; ZeroExt = v.zext; WriteReg = v.wr; wAddr = v.waddr;
        wData = v.wdata; ExMemRead = v.exMem; ExRtAddr = v.exRt;
        #1;
        chk({nm, ".Stall"}, {31'd0, Stall}, {31'd0, v.xStall});
        e.valid = v.xValid; e.refA = v.xRef; e.rd1 = v.xRd1; e.rd2 = v.xRd2;
        e.off = v.xOff; e.rs = v.xRs; e.rt = v.xRt; e.rd = v.xRd;
        e.eq = v.xEq & CMP; e.cnt = v.xCnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk({nm, ".Valid"},    {31'd0, Valid},    {31'd0, g.valid});
        chk({nm, ".RefAddr"},  RefAddr,           g.refA);
        chk({nm, ".rData1"},   rData1,            g.rd1);
        chk({nm, ".rData2"},   rData2,            g.rd2);
        chk({nm, ".Offset"},   Offset,            g.off);
        chk({nm, ".RsAddr"},   {27'd0, RsAddr},   {27'd0, g.rs});
        chk({nm, ".RtAddr"},   {27'd0, RtAddr},   {27'd0, g.rt});
        chk({nm, ".RdAddr"},   {27'd0, RdAddr},   {27'd0, g.rd});
        chk({nm, ".Eq"},       {31'd0, Eq},       {31'd0, g.eq});
        chk({nm, ".StallCnt"}, {28'd0, StallCnt}, {28'd0, g.cnt});
    endtask

    task automatic chkZero(input string nm);
        chk({nm, ".Valid"},    {31'd0, Valid}, 32'd0);
        chk({nm, ".RefAddr"},  RefAddr, 32'd0);
        chk({nm, ".rData1"},   rData1, 32'd0);
        chk({nm, ".rData2"},   rData2, 32'd0);
        chk({nm, ".Offset"},   Offset, 32'd0);
        chk({nm, ".Addrs"},    {17'd0, RsAddr, RtAddr, RdAddr}, 32'd0);
        chk({nm, ".Eq"},       {31'd0, Eq}, 32'd0);
        chk({nm, ".StallCnt"}, {28'd0, StallCnt}, 32'd0);
        chk({nm, ".Stall"},    {31'd0, Stall}, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [3:0] cntExp;

        //           en    clr   vld   refA        instr                      zext  wr    waddr  wdata        exMem exRt   xStall xValid xRef        xRd1         xRd2         xOff           xRs    xRt    xRd    xEq   xCnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0FC, mkI(5'd0, 5'd0, 16'h0000),   1'b0, 1'b1, 5'd5,  32'h1234, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0FC, 32'h0,    32'h0,    32'h0,         5'd0,  5'd0,  5'd0,  1'b1, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h100, mkI(5'd5, 5'd6, 16'h0010),   1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 1'b1, 32'h100, 32'h1234, 32'h0,    32'h10,        5'd5,  5'd6,  5'd0,  1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h104, mkI(5'd5, 5'd7, 16'h5800),   1'b0, 1'b1, 5'd7,  32'hCAFE, 1'b0, 5'd0, 1'b0, 1'b1, 32'h104, 32'h1234, 32'hCAFE, 32'h5800,      5'd5,  5'd7,  5'd11, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h108, mkI(5'd3, 5'd4, 16'h0000),   1'b0, 1'b1, 5'd3,  32'h33,   1'b1, 5'd3, 1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 4'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h108, mkI(5'd3, 5'd4, 16'h0000),   1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd3, 1'b0, 1'b1, 32'h108, 32'h33,   32'h0,    32'h0,         5'd3,  5'd4,  5'd0,  1'b0, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h10C, mkI(5'd1, 5'd4, 16'h0000),   1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd4, 1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 4'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h110, mkI(5'd4, 5'd4, 16'h0000),   1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd4, 1'b0, 1'b0, 32'h110, 32'h0,    32'h0,    32'h0,         5'd4,  5'd4,  5'd0,  1'b1, 4'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h114, mkI(5'd0, 5'd0, 16'h0000),   1'b0, 1'b1, 5'd0,  32'hFFFF, 1'b1, 5'd0, 1'b0, 1'b1, 32'h114, 32'h0,    32'h0,    32'h0,         5'd0,  5'd0,  5'd0,  1'b1, 4'd2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h118, mkI(5'd1, 5'd2, 16'h8001),   1'b0, 1'b1, 5'd1,  32'h9,    1'b0, 5'd0, 1'b0, 1'b1, 32'h118, 32'h9,    32'h0,    32'hFFFF8001,  5'd1,  5'd2,  5'd16, 1'b0, 4'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h118, mkI(5'd1, 5'd2, 16'h8001),   1'b1, 1'b1, 5'd2,  32'h9,    1'b0, 5'd0, 1'b0, 1'b1, 32'h118, 32'h9,    32'h9,    32'h00008001,  5'd1,  5'd2,  5'd16, 1'b1, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h300, mkI(5'd5, 5'd7, 16'h0000),   1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 1'b1, 1'b1, 32'h118, 32'h9,    32'h9,    32'h00008001,  5'd1,  5'd2,  5'd16, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h304, mkI(5'd6, 5'd8, 16'h1234),   1'b1, 1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 1'b0, 1'b1, 32'h118, 32'h9,    32'h9,    32'h00008001,  5'd1,  5'd2,  5'd16, 1'b1, 4'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h308, mkI(5'd9, 5'd9, 16'hFFFF),   1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 1'b1, 32'h118, 32'h9,    32'h9,    32'h00008001,  5'd1,  5'd2,  5'd16, 1'b1, 4'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h30C, mkI(5'd5, 5'd7, 16'h0000),   1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 1'b1, 1'b0, 32'h0,   32'h0,    32'h0,    32'h0,         5'd0,  5'd0,  5'd0,  1'b0, 4'd2};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h200, mkI(5'd10, 5'd7, 16'h0001),  1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 1'b1, 32'h200, 32'hAAAA, 32'hCAFE, 32'h1,         5'd10, 5'd7,  5'd0,  1'b0, 4'd2};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h204, mkI(5'd5, 5'd5, 16'hF800),   1'b0, 1'b1, 5'd5,  32'h5555, 1'b0, 5'd0, 1'b0, 1'b1, 32'h204, 32'h5555, 32'h5555, 32'hFFFFF800,  5'd5,  5'd5,  5'd31, 1'b1, 4'd2};

        rst = 1'b1; En = 1'b1; Clr = 1'b0; Valid_i = 1'b0; RefAddr_i = 32'h0;
        Instr = 26'd0; ZeroExt = 1'b0; WriteReg = 1'b0; wAddr = 5'd0;
        wData = 32'h0; ExMemRead = 1'b0; ExRtAddr = 5'd0;
        repeat (2) @(negedge clk);
        chkZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back load-use stalls drive the counter into saturation.
        cntExp = 4'd2;
        for (int i = 0; i < 16; i++) begin
            v = vecs[5];
            v.instr = mkI(5'd1, 5'd9, 16'h0000);
            v.exRt  = 5'd1;
            if (cntExp != 4'hF) cntExp = cntExp + 4'd1;
            v.xCnt  = cntExp;
            step(v, $sformatf("sat%0d", i));
        end

        // Asynchronous reset mid-cycle clears ID/EX, the counter and the register file.
        #2;
        rst = 1'b1;
        #1;
        Valid_i = 1'b0;
        ExMemRead = 1'b0;
        WriteReg = 1'b0;
        #1;
        chkZero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = vecs[1];
        v.instr = mkI(5'd5, 5'd2, 16'h0000);
        v.xRd1 = 32'h0; v.xRd2 = 32'h0; v.xOff = 32'h0; v.xRt = 5'd2;
        v.xEq = 1'b1; v.xCnt = 4'd0;
        step(v, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
